// File: rtl/bcd_mod_counter_if.sv
// Bus bundle for one bcd_mod_counter stage: control, load and alarm inputs plus count and status outputs.
// Width of the tens-digit fields follows MSD_W of the attached stage.
interface bcd_mod_counter_if #(
    parameter int MSD_W = 3
);
    logic             clear;
    logic             inc;
    logic             dec;
    logic             load_en;
    logic [3:0]       load_lsd;
    logic [MSD_W-1:0] load_msd;
    logic             alm_en;
    logic [3:0]       alm_lsd;
    logic [MSD_W-1:0] alm_msd;
    logic [3:0]       bcd_lsd;
    logic [MSD_W-1:0] bcd_msd;
    logic             carry;
    logic             borrow;
    logic             at_max;
    logic             at_min;
    logic             load_err;
    logic             alm_match;

    modport master (
        output clear, inc, dec, load_en, load_lsd, load_msd, alm_en, alm_lsd, alm_msd,
        input  bcd_lsd, bcd_msd, carry, borrow, at_max, at_min, load_err, alm_match
    );

    modport slave (
        input  clear, inc, dec, load_en, load_lsd, load_msd, alm_en, alm_lsd, alm_msd,
        output bcd_lsd, bcd_msd, carry, borrow, at_max, at_min, load_err, alm_match
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter stage (MIN_VAL..MAX_VAL) with up/down count, clear, validated load and status flags.
// Define BCD_MOD_COUNTER_ALARM_EN to enable the alarm match pulse; otherwise alm_match is tied low.
module bcd_mod_counter #(
    parameter int MAX_VAL = 59,
    parameter int MIN_VAL = 0,
    parameter int RST_VAL = 0,
    parameter int MSD_W   = 3
) (
    input logic              clk,
    input logic              rst,
    bcd_mod_counter_if.slave bus
);
    localparam logic [3:0]       MAX_LSD = 4'(MAX_VAL % 10);
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(MAX_VAL / 10);
    localparam logic [3:0]       MIN_LSD = 4'(MIN_VAL % 10);
    localparam logic [MSD_W-1:0] MIN_MSD = MSD_W'(MIN_VAL / 10);
    localparam logic [3:0]       RST_LSD = 4'(RST_VAL % 10);
    localparam logic [MSD_W-1:0] RST_MSD = MSD_W'(RST_VAL / 10);

    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             load_err_q, load_err_d;
    logic             alm_match_q, alm_match_d;
    logic             at_max, at_min;
    logic             count_up, count_down;
    logic             load_ok;
    int               load_val;

    assign at_max     = (msd_q == MAX_MSD) && (lsd_q == MAX_LSD);
    assign at_min     = (msd_q == MIN_MSD) && (lsd_q == MIN_LSD);
    assign count_up   = bus.inc & ~bus.dec;
    assign count_down = bus.dec & ~bus.inc;
    assign load_val   = 10 * int'(bus.load_msd) + int'(bus.load_lsd);
    assign load_ok    = (bus.load_lsd <= 4'd9) && (load_val >= MIN_VAL) && (load_val <= MAX_VAL);

    always_comb begin
        lsd_d      = lsd_q;
        msd_d      = msd_q;
        load_err_d = 1'b0;
        if (bus.clear) begin
            lsd_d = MIN_LSD;
            msd_d = MIN_MSD;
        end else if (bus.load_en) begin
            if (load_ok) begin
                lsd_d = bus.load_lsd;
                msd_d = bus.load_msd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (count_up) begin
            if (at_max) begin
                lsd_d = MIN_LSD;
                msd_d = MIN_MSD;
            end else if (lsd_q == 4'd9) begin
                lsd_d = 4'd0;
                msd_d = msd_q + MSD_W'(1);
            end else begin
                lsd_d = lsd_q + 4'd1;
            end
        end else if (count_down) begin
            if (at_min) begin
                lsd_d = MAX_LSD;
                msd_d = MAX_MSD;
            end else if (lsd_q == 4'd0) begin
                lsd_d = 4'd9;
                msd_d = msd_q - MSD_W'(1);
            end else begin
                lsd_d = lsd_q - 4'd1;
            end
        end
    end

`ifdef BCD_MOD_COUNTER_ALARM_EN
    // Fire only when the count actually moves onto the alarm value, so holding or retargeting never re-triggers.
    always_comb begin
        alm_match_d = bus.alm_en
                    && ({msd_d, lsd_d} != {msd_q, lsd_q})
                    && (msd_d == bus.alm_msd)
                    && (lsd_d == bus.alm_lsd);
    end
`else
    logic alm_unused;
    assign alm_unused  = ^{bus.alm_en, bus.alm_lsd, bus.alm_msd};
    assign alm_match_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsd_q       <= RST_LSD;
            msd_q       <= RST_MSD;
            load_err_q  <= 1'b0;
            alm_match_q <= 1'b0;
        end else begin
            lsd_q       <= lsd_d;
            msd_q       <= msd_d;
            load_err_q  <= load_err_d;
            alm_match_q <= alm_match_d;
        end
    end

    // Carry/borrow stay combinational so a cascaded stage rolls over on the same edge as this one.
    assign bus.carry     = bus.inc & ~bus.dec & ~bus.clear & ~bus.load_en & at_max;
    assign bus.borrow    = bus.dec & ~bus.inc & ~bus.clear & ~bus.load_en & at_min;
    assign bus.at_max    = at_max;
    assign bus.at_min    = at_min;
    assign bus.bcd_lsd   = lsd_q;
    assign bus.bcd_msd   = msd_q;
    assign bus.load_err  = load_err_q;
    assign bus.alm_match = alm_match_q;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: a default 00..59 stage, a 01..12 hour stage, and a 00..23 stage cascaded from the first.
// Alarm expectations follow BCD_MOD_COUNTER_ALARM_EN.
module tb_bcd_mod_counter;
`ifdef BCD_MOD_COUNTER_ALARM_EN
    localparam int ALM_HIT = 1;
`else
    localparam int ALM_HIT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   val_a, val_b, val_h;

    bcd_mod_counter_if #(.MSD_W(3)) bus_a ();
    bcd_mod_counter_if #(.MSD_W(2)) bus_b ();
    bcd_mod_counter_if #(.MSD_W(1)) bus_h ();

    bcd_mod_counter #(.MAX_VAL(59), .MIN_VAL(0), .RST_VAL(0), .MSD_W(3))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bcd_mod_counter #(.MAX_VAL(23), .MIN_VAL(0), .RST_VAL(0), .MSD_W(2))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    bcd_mod_counter #(.MAX_VAL(12), .MIN_VAL(1), .RST_VAL(12), .MSD_W(1))
        dut_h (.clk(clk), .rst(rst), .bus(bus_h));

    always #5 clk = ~clk;

    // The hours stage counts on the minutes stage's carry.
    assign bus_b.inc = bus_a.carry;

    assign val_a = 10 * int'(bus_a.bcd_msd) + int'(bus_a.bcd_lsd);
    assign val_b = 10 * int'(bus_b.bcd_msd) + int'(bus_b.bcd_lsd);
    assign val_h = 10 * int'(bus_h.bcd_msd) + int'(bus_h.bcd_lsd);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic clr, input logic up, input logic dn, input logic ld,
                                  input logic [2:0] msd, input logic [3:0] lsd);
        bus_a.clear    = clr;
        bus_a.inc      = up;
        bus_a.dec      = dn;
        bus_a.load_en  = ld;
        bus_a.load_msd = msd;
        bus_a.load_lsd = lsd;
    endtask

    initial begin
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        bus_a.alm_en = 1'b0; bus_a.alm_msd = 3'd0; bus_a.alm_lsd = 4'd0;
        bus_b.clear = 1'b0; bus_b.dec = 1'b0; bus_b.load_en = 1'b0;
        bus_b.load_msd = 2'd0; bus_b.load_lsd = 4'd0;
        bus_b.alm_en = 1'b0; bus_b.alm_msd = 2'd0; bus_b.alm_lsd = 4'd0;
        bus_h.clear = 1'b0; bus_h.inc = 1'b0; bus_h.dec = 1'b0; bus_h.load_en = 1'b0;
        bus_h.load_msd = 1'd0; bus_h.load_lsd = 4'd0;
        bus_h.alm_en = 1'b0; bus_h.alm_msd = 1'd0; bus_h.alm_lsd = 4'd0;

        // Reset state
        #2 rst = 1'b0;
        tick();
        tick();
        check_output("rst_val_a", val_a, 0);
        check_output("rst_val_b", val_b, 0);
        check_output("rst_val_h", val_h, 12);
        check_output("rst_load_err", int'(bus_a.load_err), 0);
        check_output("rst_alm_match", int'(bus_a.alm_match), 0);
        check_output("rst_at_min_a", int'(bus_a.at_min), 1);
        check_output("rst_at_max_h", int'(bus_h.at_max), 1);
        rst = 1'b1;

        // Full 00..59 sweep and wrap
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
            #1;
            check_output("sweep_val", val_a, i);
            check_output("sweep_carry", int'(bus_a.carry), (i == 59) ? 1 : 0);
            check_output("sweep_at_max", int'(bus_a.at_max), (i == 59) ? 1 : 0);
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("sweep_wrap", val_a, 0);
        check_output("sweep_cascade_b", val_b, 1);

        // 12-hour stage: 12 -> 01 -> 12 -> 11
        bus_h.inc = 1'b1;
        #1 check_output("h12_carry", int'(bus_h.carry), 1);
        tick();
        bus_h.inc = 1'b0;
        check_output("h12_wrap_up", val_h, 1);
        check_output("h12_at_min", int'(bus_h.at_min), 1);
        bus_h.dec = 1'b1;
        #1 check_output("h12_borrow", int'(bus_h.borrow), 1);
        tick();
        check_output("h12_wrap_down", val_h, 12);
        #1 check_output("h12_no_borrow", int'(bus_h.borrow), 0);
        tick();
        bus_h.dec = 1'b0;
        check_output("h12_dec", val_h, 11);

        // Load accept and reject
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 4'd7);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("load_47", val_a, 47);
        check_output("load_47_err", int'(bus_a.load_err), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 4'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("load_60_val", val_a, 47);
        check_output("load_60_err", int'(bus_a.load_err), 1);
        tick();
        check_output("load_err_one_cycle", int'(bus_a.load_err), 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 4'hA);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("load_lsdA_val", val_a, 47);
        check_output("load_lsdA_err", int'(bus_a.load_err), 1);
        tick();
        check_output("load_lsdA_err_clr", int'(bus_a.load_err), 0);

        // Priority: clear over load and inc
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd0);
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 4'd5);
        #1 check_output("clear_carry", int'(bus_a.carry), 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("clear_val", val_a, 0);
        check_output("clear_load_err", int'(bus_a.load_err), 0);

        // Down-wrap from 00 and inc+dec hold at 59
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        #1 check_output("dec_wrap_borrow", int'(bus_a.borrow), 1);
        tick();
        check_output("dec_wrap_val", val_a, 59);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
        #1 check_output("both_carry", int'(bus_a.carry), 0);
        check_output("both_borrow", int'(bus_a.borrow), 0);
        tick();
        check_output("both_hold", val_a, 59);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 4'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("dec_digit_borrow", val_a, 49);

        // Cascade 59/23 rollover, then asynchronous reset mid-cycle
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 4'd9);
        bus_b.load_en = 1'b1; bus_b.load_msd = 2'd2; bus_b.load_lsd = 4'd3;
        tick();
        bus_b.load_en = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("casc_pre_a", val_a, 59);
        check_output("casc_pre_b", val_b, 23);
        #1 check_output("casc_carry_a", int'(bus_a.carry), 1);
        check_output("casc_carry_b", int'(bus_b.carry), 1);
        tick();
        check_output("casc_roll_a", val_a, 0);
        check_output("casc_roll_b", val_b, 0);
        bus_b.load_en = 1'b1; bus_b.load_msd = 2'd0; bus_b.load_lsd = 4'd7;
        tick();
        bus_b.load_en = 1'b0;
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("pre_rst_a", val_a, 3);
        check_output("pre_rst_b", val_b, 7);
        #2 rst = 1'b0;
        #1 check_output("async_rst_a", val_a, 0);
        check_output("async_rst_b", val_b, 0);
        check_output("async_rst_h", val_h, 12);
        tick();
        rst = 1'b1;

        // Alarm at 05
        bus_a.alm_en = 1'b1; bus_a.alm_msd = 3'd0; bus_a.alm_lsd = 4'd5;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd3);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("alm_at_03", int'(bus_a.alm_match), 0);
        tick();
        check_output("alm_at_04", int'(bus_a.alm_match), 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check_output("alm_val_05", val_a, 5);
        check_output("alm_hit", int'(bus_a.alm_match), ALM_HIT);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("alm_hold", int'(bus_a.alm_match), 0);
        end
        bus_a.alm_lsd = 4'd7;
        tick();
        bus_a.alm_lsd = 4'd5;
        tick();
        check_output("alm_retarget", int'(bus_a.alm_match), 0);
        check_output("alm_final_val", val_a, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter stage for the top-down clock; generalises the fixed 00..59 minute stage.
- A single block serves seconds (0..59), minutes (0..59), 24-hour hours (0..23) and 12-hour hours (1..12).
- Adds down-counting, synchronous clear, validated parallel load for time setting, and status flags.
- Stages cascade: the carry/borrow of one stage drives inc/dec of the next.

Parameters:
- MAX_VAL, 59, highest count value (decimal); legal range 1..99.
- MIN_VAL, 0, lowest count value; legal range 0..MAX_VAL-1 (1 for 12-hour hours).
- RST_VAL, 0, value loaded on reset; legal range MIN_VAL..MAX_VAL.
- MSD_W, 3, width of the tens digit; must satisfy 2**MSD_W > MAX_VAL/10.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- clear  in  1  synchronous return to MIN_VAL
- inc  in  1  count-up enable, one step per cycle
- dec  in  1  count-down enable, one step per cycle
- load_en  in  1  parallel load strobe
- load_lsd  in  4  load value, units digit
- load_msd  in  MSD_W  load value, tens digit
- alm_en  in  1  alarm compare enable
- alm_lsd  in  4  alarm value, units digit
- alm_msd  in  MSD_W  alarm value, tens digit
- bcd_lsd  out  4  count, units digit (registered)
- bcd_msd  out  MSD_W  count, tens digit (registered)
- carry  out  1  combinational; next stage increments
- borrow  out  1  combinational; next stage decrements
- at_max  out  1  combinational; count == MAX_VAL
- at_min  out  1  combinational; count == MIN_VAL
- load_err  out  1  registered one-cycle pulse; load rejected
- alm_match  out  1  registered one-cycle pulse; count reached alarm value

Behaviour:
- Reset (rst low, asynchronous): count = RST_VAL split into digits; load_err = 0; alm_match = 0.
- Per-cycle priority: clear > load_en > (inc XOR dec). When inc and dec are both high with no clear/load, the count holds and neither carry nor borrow asserts.
- Value V = 10*bcd_msd + bcd_lsd. bcd_lsd is always 0..9; V is always in MIN_VAL..MAX_VAL.
- Increment (inc only):
  - V < MAX_VAL: bcd_lsd 9 -> 0 with bcd_msd +1; otherwise bcd_lsd +1.
  - V == MAX_VAL: V wraps to MIN_VAL.
- Decrement (dec only):
  - V > MIN_VAL: bcd_lsd 0 -> 9 with bcd_msd -1; otherwise bcd_lsd -1.
  - V == MIN_VAL: V wraps to MAX_VAL.
- carry = inc & ~dec & ~clear & ~load_en & at_max, in the same cycle as the wrap. No register delay, so cascaded stages roll over on the same edge.
- borrow = dec & ~inc & ~clear & ~load_en & at_min.
- Load: accepted when load_lsd <= 9 and MIN_VAL <= 10*load_msd + load_lsd <= MAX_VAL. The count takes the load value at the next edge.
- Rejected load: count unchanged; load_err = 1 for exactly the following cycle. inc/dec in the same cycle are still ignored.
- clear sets V = MIN_VAL. clear never produces carry, borrow or load_err.
- Load and clear never produce carry/borrow.
- Latency: count updates one clock after the qualifying input; carry, borrow, at_max and at_min are zero-latency.

Optional Feature:
- Macro: BCD_MOD_COUNTER_ALARM_EN.
- Defined:
  - alm_match pulses for one cycle when alm_en = 1 and the registered count changes to a value equal to {alm_msd, alm_lsd}.
  - Qualifying changes are inc, dec, load or clear; pulse appears the cycle after the update.
  - A count that merely holds at the alarm value does not re-trigger. Changing alm_lsd/alm_msd to equal the current count does not trigger.
- Not defined: alm_* inputs are ignored; alm_match is tied 0. Ports remain present.

Test Plan:
- Default params, reset, then 60 inc pulses: count 00..59 then 00. carry high only in the cycle V = 59 with inc. at_max high only at 59.
- MAX_VAL = 12, MIN_VAL = 1, RST_VAL = 12: inc -> 01. Then dec at 01 -> 12, with borrow = 1 in that cycle. Count 00 is never produced.
- Default params, load 4/7 (47) -> count 47, load_err = 0. Load 6/0 (60) -> count stays 47, load_err pulses 1 cycle. Load lsd = 0xA -> rejected likewise.
- Default params, count 30, clear + load_en + inc in the same cycle -> count 00, no carry, no load_err. inc + dec together at 59 -> holds 59, carry = 0.
- Two stages cascaded (59 and 23 limits) at 59/23, one inc -> both 00 on the same edge. Assert rst mid-sequence -> both return to RST_VAL immediately, without waiting for a clock edge.
- ALARM_EN defined, alarm 0/5, alm_en = 1, count 03, two inc -> alm_match pulses once on reaching 05. Hold 5 cycles -> no further pulse. Macro undefined -> alm_match = 0 throughout.
